// File: rtl/gene_net_pkg.sv
// Shared definitions for the 8-gene Boolean network: the single-step update F and FSM states.
package gene_net_pkg;

  localparam int N_GENES = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } scan_state_t;

  function automatic logic [7:0] gene_step(input logic [7:0] c);
    logic [7:0] n;
    n[0] = ~c[2] & c[6] & ~c[7];
    n[1] = (c[4] | c[5]) & ~c[7];
    n[2] = c[7];
    n[3] = c[1] & ~c[6];
    n[4] = c[1] | c[3];
    n[5] = c[2] & ~c[7];
    n[6] = c[1] & ~c[7];
    n[7] = ~(c[0] | c[1]) & (c[3] | c[6]);
    return n;
  endfunction

endpackage

// File: rtl/gene_net_iter.sv
// Combinational DEPTH-fold application of the network update F.
module gene_net_iter
  import gene_net_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic [7:0] cur,
  output logic [7:0] nxt
);

  logic [7:0] stage [DEPTH+1];

  assign stage[0] = cur;

  for (genvar i = 0; i < DEPTH; i++) begin : g_step
    assign stage[i+1] = gene_step(stage[i]);
  end

  assign nxt = stage[DEPTH];

endmodule

// File: rtl/gene_net_preimage.sv
// Predecessor scanner: streams every c with F^DEPTH(c) == target, flags garden-of-Eden targets.
// Optional GENE_PREIMAGE_COUNT_EN adds a pred_count output with the number of accepted matches.
//
//  state  | meaning
//  S_IDLE | waiting for start; garden/pred_count hold last result
//  S_SCAN | testing one candidate per cycle, stalls on unaccepted match
//  S_DONE | one-cycle done pulse, result valid
module gene_net_preimage
  import gene_net_pkg::*;
#(
  parameter int DEPTH   = 1,
  parameter int N_GENES = 8
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               start,
  input  logic [N_GENES-1:0] target,
  output logic               busy,
  output logic               pred_valid,
  input  logic               pred_ready,
  output logic [N_GENES-1:0] pred,
  output logic               done,
  output logic               garden
`ifdef GENE_PREIMAGE_COUNT_EN
  ,
  output logic [N_GENES:0]   pred_count
`endif
);

  scan_state_t        state;
  logic [N_GENES:0]   cand;
  logic [N_GENES-1:0] tgt;
  logic [N_GENES-1:0] image;
  logic               found;
  logic               match;
  logic               accept;
  logic               advance;

  gene_net_iter #(.DEPTH(DEPTH)) u_iter (
    .cur (cand[N_GENES-1:0]),
    .nxt (image)
  );

  assign match      = (image == tgt);
  assign pred_valid = (state == S_SCAN) && match;
  assign pred       = cand[N_GENES-1:0];
  assign accept     = pred_valid && pred_ready;
  // A held match keeps pred stable until the consumer takes it.
  assign advance    = (state == S_SCAN) && (!match || pred_ready);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state  <= S_IDLE;
      cand   <= '0;
      tgt    <= '0;
      found  <= 1'b0;
      garden <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef GENE_PREIMAGE_COUNT_EN
      pred_count <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            tgt    <= target;
            cand   <= '0;
            found  <= 1'b0;
            garden <= 1'b0;
            busy   <= 1'b1;
            state  <= S_SCAN;
`ifdef GENE_PREIMAGE_COUNT_EN
            pred_count <= '0;
`endif
          end
        end
        S_SCAN: begin
          if (accept) begin
            found <= 1'b1;
`ifdef GENE_PREIMAGE_COUNT_EN
            pred_count <= pred_count + 1'b1;
`endif
          end
          if (advance) begin
            cand <= cand + 1'b1;
            // Garden is resolved on the way into DONE so it is valid alongside the pulse.
            if (cand == 9'd255) begin
              state  <= S_DONE;
              done   <= 1'b1;
              garden <= ~(found | accept);
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gene_net_preimage.sv
// Directed bench for gene_net_preimage: DEPTH=1 and DEPTH=2 instances share the input stimulus.
module tb_gene_net_preimage;
  import gene_net_pkg::*;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       start = 1'b0;
  logic       pred_ready = 1'b1;
  logic [7:0] target = 8'h00;

  logic       busy1, pv1, done1, garden1;
  logic [7:0] pred1;
  logic       busy2, pv2, done2, garden2;
  logic [7:0] pred2;
`ifdef GENE_PREIMAGE_COUNT_EN
  logic [8:0] cnt1, cnt2;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gene_net_preimage #(.DEPTH(1)) dut1 (
    .clk(clk), .n_reset(n_reset), .start(start), .target(target),
    .busy(busy1), .pred_valid(pv1), .pred_ready(pred_ready), .pred(pred1),
    .done(done1), .garden(garden1)
`ifdef GENE_PREIMAGE_COUNT_EN
    , .pred_count(cnt1)
`endif
  );

  gene_net_preimage #(.DEPTH(2)) dut2 (
    .clk(clk), .n_reset(n_reset), .start(start), .target(target),
    .busy(busy2), .pred_valid(pv2), .pred_ready(pred_ready), .pred(pred2),
    .done(done2), .garden(garden2)
`ifdef GENE_PREIMAGE_COUNT_EN
    , .pred_count(cnt2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    start = 1'b0;
    pred_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
  endtask

  // Returns in the first SCAN cycle (one cycle after the accept edge).
  task automatic start_scan(input logic [7:0] t);
    @(negedge clk);
    start = 1'b1;
    target = t;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_scan(input int which, input logic [7:0] t, input bit inject,
                          output int npred, output logic [7:0] first, output int done_k,
                          output logic gard, output logic [8:0] cnt);
    logic       v, d, b, seen;
    logic [7:0] p, last, m;
    npred = 0; first = 8'h00; done_k = 0; gard = 1'b0; cnt = 9'd0;
    seen = 1'b0; last = 8'h00;
    start_scan(t);
    for (int k = 1; k <= 400; k++) begin
      v = (which == 2) ? pv2 : pv1;
      d = (which == 2) ? done2 : done1;
      b = (which == 2) ? busy2 : busy1;
      p = (which == 2) ? pred2 : pred1;
      if (v) begin
        m = p;
        for (int i = 0; i < which; i++) m = gene_step(m);
        check("pred_model", {24'd0, m}, {24'd0, t});
        if (seen) check("pred_order", {31'd0, p > last}, 32'd1);
        else first = p;
        seen = 1'b1;
        last = p;
        npred++;
      end
      if (d) begin
        done_k = k;
        gard = (which == 2) ? garden2 : garden1;
        check("busy_in_done", {31'd0, b}, 32'd1);
        check("valid_in_done", {31'd0, v}, 32'd0);
`ifdef GENE_PREIMAGE_COUNT_EN
        cnt = (which == 2) ? cnt2 : cnt1;
`endif
        break;
      end
      if (inject) begin
        start = (k == 10 || k == 140);
        target = start ? 8'hFF : t;
      end
      @(negedge clk);
    end
    if (done_k == 0) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      start = inject;
      target = inject ? 8'hFF : t;
      @(negedge clk);
      start = 1'b0;
      check("idle_after_done", {31'd0, (which == 2) ? busy2 : busy1}, 32'd0);
    end
  endtask

  int         np, dk, k;
  logic [7:0] fp;
  logic       gd, seen_done;
  logic [8:0] cn;

  initial begin
    // Reset state
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_valid", {31'd0, pv1}, 32'd0);
    check("rst_pred", {24'd0, pred1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_garden", {31'd0, garden1}, 32'd0);
    n_reset = 1'b1;
    @(negedge clk);

    // Unsatisfiable target: n2 and n5 cannot both be set
    run_scan(1, 8'h24, 1'b0, np, fp, dk, gd, cn);
    check("t2_npred", np, 32'd0);
    check("t2_done_cycle", dk, 32'd257);
    check("t2_garden", {31'd0, gd}, 32'd1);
    repeat (3) @(negedge clk);
    check("t2_garden_held", {31'd0, garden1}, 32'd1);
`ifdef GENE_PREIMAGE_COUNT_EN
    check("t2_count", {23'd0, cn}, 32'd0);
`endif

    // Basic stream for T=0x04
    run_scan(1, 8'h04, 1'b0, np, fp, dk, gd, cn);
    check("t1_first", {24'd0, fp}, 32'h80);
    check("t1_npred", np, 32'd24);
    check("t1_done_cycle", dk, 32'd257);
    check("t1_garden", {31'd0, gd}, 32'd0);
`ifdef GENE_PREIMAGE_COUNT_EN
    check("t1_count", {23'd0, cn}, 32'd24);
`endif

    // Backpressure on the first match
    do_reset();
    start_scan(8'h04);
    k = 0;
    while (!pv1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("bp_first_pred", {24'd0, pred1}, 32'h80);
    pred_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", {31'd0, pv1}, 32'd1);
      check("bp_hold_pred", {24'd0, pred1}, 32'h80);
      @(negedge clk);
    end
    check("bp_still_held", {24'd0, pred1}, 32'h80);
    pred_ready = 1'b1;
    @(negedge clk);
    check("bp_next_pred", {24'd0, pred1}, 32'h81);
    check("bp_next_valid", {31'd0, pv1}, 32'd1);
    k = 0;
    while (!done1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("bp_done_seen", {31'd0, done1}, 32'd1);
`ifdef GENE_PREIMAGE_COUNT_EN
    check("bp_count", {23'd0, cnt1}, 32'd24);
`endif

    // Reset mid-scan, then restart with T=0x00
    do_reset();
    start_scan(8'h04);
    k = 0;
    while (pred1 != 8'h40 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("mid_reached_40", {24'd0, pred1}, 32'h40);
    n_reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy1}, 32'd0);
    check("mid_rst_valid", {31'd0, pv1}, 32'd0);
    check("mid_rst_pred", {24'd0, pred1}, 32'd0);
    n_reset = 1'b1;
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done1 || busy1) seen_done = 1'b1;
    end
    check("mid_no_done", {31'd0, seen_done}, 32'd0);
    start_scan(8'h00);
    check("t4_first_valid", {31'd0, pv1}, 32'd1);
    check("t4_first_pred", {24'd0, pred1}, 32'h00);

    // start pulses during scan and in the DONE cycle are ignored
    do_reset();
    run_scan(1, 8'h04, 1'b1, np, fp, dk, gd, cn);
    check("t5_first", {24'd0, fp}, 32'h80);
    check("t5_npred", np, 32'd24);
    check("t5_done_cycle", dk, 32'd257);
`ifdef GENE_PREIMAGE_COUNT_EN
    check("t5_count", {23'd0, cn}, 32'd24);
`endif

    // DEPTH=2: 0x80 -> 0x04 -> 0x20
    do_reset();
    run_scan(2, 8'h20, 1'b0, np, fp, dk, gd, cn);
    check("t6_first", {24'd0, fp}, 32'h80);
    check("t6_npred", np, 32'd24);
    check("t6_garden", {31'd0, gd}, 32'd0);
`ifdef GENE_PREIMAGE_COUNT_EN
    check("t6_count", {23'd0, cn}, 32'd24);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
